// File: rtl/ctlb_assoc_gen.sv
// Set-associative code TLB with ASID/global tagging, true-LRU ages,
// registered lookup results, single-page invalidate and flush sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | post-reset sweep, clears one set per cycle, busy=1
// ST_IDLE  | serving fill > inv > lookup
// ST_FLUSH | flush_all sweep, clears one set per cycle, busy=1
module ctlb_assoc_gen #(
    parameter int WAYS      = 4,
    parameter int SETS_LOG2 = 6,
    parameter int VA_W      = 65,
    parameter int ASID_W    = 21,
    parameter int DATA_W    = 44
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_en,
    input  logic [VA_W-1:0]   lookup_addr,
    input  logic [ASID_W-1:0] lookup_asid,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data,
    input  logic              fill_en,
    input  logic [VA_W-1:0]   fill_addr,
    input  logic [ASID_W-1:0] fill_asid,
    input  logic              fill_global,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_en,
    input  logic [VA_W-1:0]   inv_addr,
    input  logic              flush_all,
    output logic              busy
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int AGE_W = $clog2(WAYS);
    localparam int TAG_W = VA_W - 14 - SETS_LOG2;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_t;

    state_t                 state_q;
    logic [SETS_LOG2-1:0]   sweep_cnt;

    logic [WAYS-1:0]        valid_q  [SETS];
    logic [WAYS-1:0]        global_q [SETS];
    logic [TAG_W-1:0]       tag_q    [SETS][WAYS];
    logic [ASID_W-1:0]      asid_q   [SETS][WAYS];
    logic [DATA_W-1:0]      data_q   [SETS][WAYS];
    logic [AGE_W-1:0]       age_q    [SETS][WAYS];

    logic [SETS_LOG2-1:0]   l_idx, f_idx, i_idx;
    logic [TAG_W-1:0]       l_tag, f_tag, i_tag;
    logic [WAYS-1:0]        l_match, f_match, i_match;
    logic                   l_hit_any, f_hit_any, f_free_any;
    logic [AGE_W-1:0]       l_way, f_match_way, f_free_way, f_old_way, f_way;
    logic                   idle, do_fill, do_inv, do_look;
    logic                   unused_bits;

    assign l_idx = lookup_addr[14 +: SETS_LOG2];
    assign f_idx = fill_addr[14 +: SETS_LOG2];
    assign i_idx = inv_addr[14 +: SETS_LOG2];
    assign l_tag = lookup_addr[VA_W-1 -: TAG_W];
    assign f_tag = fill_addr[VA_W-1 -: TAG_W];
    assign i_tag = inv_addr[VA_W-1 -: TAG_W];
    assign unused_bits = ^{lookup_addr[13:0], fill_addr[13:0], inv_addr[13:0]};

    assign idle    = (state_q == ST_IDLE);
    assign do_fill = idle && fill_en;
    assign do_inv  = idle && !fill_en && inv_en;
    assign do_look = idle && !fill_en && !inv_en && lookup_en;

    // A way moving to age 0 pushes every younger way back by one, keeping ages a permutation.
    function automatic logic [AGE_W-1:0] next_age(input logic [AGE_W-1:0] cur,
                                                  input logic [AGE_W-1:0] ref_age,
                                                  input logic             is_sel);
        if (is_sel)              return '0;
        else if (cur < ref_age)  return cur + 1'b1;
        else                     return cur;
    endfunction

    // Tag compare and way selection for lookup, fill and invalidate; lowest way wins ties.
    always_comb begin
        l_match     = '0;
        f_match     = '0;
        i_match     = '0;
        l_hit_any   = 1'b0;
        f_hit_any   = 1'b0;
        f_free_any  = 1'b0;
        l_way       = '0;
        f_match_way = '0;
        f_free_way  = '0;
        f_old_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            l_match[w] = valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag) &&
                         (global_q[l_idx][w] || (asid_q[l_idx][w] == lookup_asid));
            f_match[w] = valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag) &&
                         (global_q[f_idx][w] || (asid_q[f_idx][w] == fill_asid));
            i_match[w] = valid_q[i_idx][w] && (tag_q[i_idx][w] == i_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (l_match[w]) begin
                l_hit_any = 1'b1;
                l_way     = AGE_W'(w);
            end
            if (f_match[w]) begin
                f_hit_any   = 1'b1;
                f_match_way = AGE_W'(w);
            end
            if (!valid_q[f_idx][w]) begin
                f_free_any = 1'b1;
                f_free_way = AGE_W'(w);
            end
            if (age_q[f_idx][w] == AGE_W'(WAYS - 1)) begin
                f_old_way = AGE_W'(w);
            end
        end
        f_way = f_hit_any ? f_match_way : (f_free_any ? f_free_way : f_old_way);
    end

    // Entry storage: sweep clears, fill writes the victim, inv clears matches, hits refresh LRU.
    always_ff @(posedge clk) begin
        if (!idle) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[sweep_cnt][w] <= 1'b0;
                age_q[sweep_cnt][w]   <= AGE_W'(w);
            end
        end else if (do_fill) begin
            valid_q[f_idx][f_way]  <= 1'b1;
            global_q[f_idx][f_way] <= fill_global;
            tag_q[f_idx][f_way]    <= f_tag;
            asid_q[f_idx][f_way]   <= fill_asid;
            data_q[f_idx][f_way]   <= fill_data;
            for (int w = 0; w < WAYS; w++) begin
                age_q[f_idx][w] <= next_age(age_q[f_idx][w], age_q[f_idx][f_way],
                                            AGE_W'(w) == f_way);
            end
        end else if (do_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (i_match[w]) valid_q[i_idx][w] <= 1'b0;
            end
        end else if (do_look && l_hit_any) begin
            for (int w = 0; w < WAYS; w++) begin
                age_q[l_idx][w] <= next_age(age_q[l_idx][w], age_q[l_idx][l_way],
                                            AGE_W'(w) == l_way);
            end
        end
    end

    // Control FSM, sweep counter and registered lookup result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            sweep_cnt   <= '0;
            busy        <= 1'b1;
            lookup_hit  <= 1'b0;
            lookup_data <= '0;
        end else begin
            lookup_hit  <= do_look && l_hit_any;
            lookup_data <= (do_look && l_hit_any) ? data_q[l_idx][l_way] : '0;
            case (state_q)
                ST_INIT, ST_FLUSH: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == '1) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (flush_all) begin
                        state_q <= ST_FLUSH;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    sweep_cnt <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctlb_assoc_gen.sv
// Directed bench for ctlb_assoc_gen at default parameters (4 ways, 64 sets).
module tb_ctlb_assoc_gen;

    logic        clk;
    logic        rst;
    logic        lookup_en;
    logic [64:0] lookup_addr;
    logic [20:0] lookup_asid;
    logic        lookup_hit;
    logic [43:0] lookup_data;
    logic        fill_en;
    logic [64:0] fill_addr;
    logic [20:0] fill_asid;
    logic        fill_global;
    logic [43:0] fill_data;
    logic        inv_en;
    logic [64:0] inv_addr;
    logic        flush_all;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    ctlb_assoc_gen dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .lookup_addr(lookup_addr), .lookup_asid(lookup_asid),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_asid(fill_asid),
        .fill_global(fill_global), .fill_data(fill_data),
        .inv_en(inv_en), .inv_addr(inv_addr),
        .flush_all(flush_all), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic lookup_op(input logic [64:0] a, input logic [20:0] s,
                             output logic hit, output logic [43:0] d);
        lookup_en = 1'b1; lookup_addr = a; lookup_asid = s;
        @(posedge clk); @(negedge clk);
        lookup_en = 1'b0;
        hit = lookup_hit; d = lookup_data;
    endtask

    task automatic fill_op(input logic [64:0] a, input logic [20:0] s,
                           input logic g, input logic [43:0] d);
        fill_en = 1'b1; fill_addr = a; fill_asid = s; fill_global = g; fill_data = d;
        @(posedge clk); @(negedge clk);
        fill_en = 1'b0; fill_global = 1'b0;
    endtask

    task automatic inv_op(input logic [64:0] a);
        inv_en = 1'b1; inv_addr = a;
        @(posedge clk); @(negedge clk);
        inv_en = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    function automatic logic [64:0] set3_addr(input int t);
        logic [64:0] a;
        a = 65'(t) * 65'h10_0000 + 65'hC000;
        return a;
    endfunction

    localparam logic [64:0] A1 = 65'h12_4000;
    localparam logic [64:0] G1 = 65'h20_8000;
    localparam logic [64:0] P1 = 65'h30_4000;
    localparam logic [64:0] Q1 = 65'h40_8000;
    localparam logic [64:0] Z1 = 65'h70_0000;

    logic        h;
    logic [43:0] d;
    int          n;
    int          hits;

    initial begin
        rst = 1'b0; lookup_en = 1'b0; lookup_addr = '0; lookup_asid = '0;
        fill_en = 1'b0; fill_addr = '0; fill_asid = '0; fill_global = 1'b0; fill_data = '0;
        inv_en = 1'b0; inv_addr = '0; flush_all = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd1);
        check_val("rst_hit", 64'(lookup_hit), 64'd0);
        check_val("rst_data", 64'(lookup_data), 64'd0);

        rst = 1'b1;
        count_busy(n);
        check_val("init_len", 64'(n), 64'd64);
        lookup_op(65'h4000, 21'd0, h, d);
        check_val("empty_miss", 64'(h), 64'd0);

        fill_op(A1, 21'd5, 1'b0, 44'hABC);
        lookup_op(A1, 21'd5, h, d);
        check_val("a1_hit", 64'(h), 64'd1);
        check_val("a1_data", 64'(d), 64'hABC);
        lookup_op(A1, 21'd6, h, d);
        check_val("a1_asid_miss", 64'(h), 64'd0);
        check_val("a1_miss_data", 64'(d), 64'd0);

        fill_op(G1, 21'd1, 1'b1, 44'h777);
        lookup_op(G1, 21'd9, h, d);
        check_val("glob_hit", 64'(h), 64'd1);
        check_val("glob_data", 64'(d), 64'h777);
        inv_op(G1);
        lookup_op(G1, 21'd9, h, d);
        check_val("glob_inv_miss", 64'(h), 64'd0);

        // Ages after 4 fills: [3,2,1,0]; touching ways 0,1,2 leaves way 3 oldest.
        for (int t = 1; t <= 4; t++) fill_op(set3_addr(t), 21'd2, 1'b0, 44'(256 + t));
        for (int t = 1; t <= 3; t++) lookup_op(set3_addr(t), 21'd2, h, d);
        fill_op(set3_addr(5), 21'd2, 1'b0, 44'd261);
        for (int t = 1; t <= 5; t++) begin
            lookup_op(set3_addr(t), 21'd2, h, d);
            check_val($sformatf("lru_hit_%0d", t), 64'(h), (t == 4) ? 64'd0 : 64'd1);
            check_val($sformatf("lru_data_%0d", t), 64'(d), (t == 4) ? 64'd0 : 64'(256 + t));
        end

        // A duplicate in a higher way would lose to the old copy in way 0.
        fill_op(A1, 21'd5, 1'b0, 44'h55);
        lookup_op(A1, 21'd5, h, d);
        check_val("refill_data", 64'(d), 64'h55);

        // fill beats lookup
        fill_en = 1'b1; fill_addr = P1; fill_asid = 21'd3; fill_data = 44'h333;
        lookup_en = 1'b1; lookup_addr = A1; lookup_asid = 21'd5;
        @(posedge clk); @(negedge clk);
        fill_en = 1'b0; lookup_en = 1'b0;
        check_val("fill_vs_look", 64'(lookup_hit), 64'd0);
        lookup_op(P1, 21'd3, h, d);
        check_val("p1_data", 64'(d), 64'h333);

        // inv beats lookup
        inv_en = 1'b1; inv_addr = P1;
        lookup_en = 1'b1; lookup_addr = P1; lookup_asid = 21'd3;
        @(posedge clk); @(negedge clk);
        inv_en = 1'b0; lookup_en = 1'b0;
        check_val("inv_vs_look", 64'(lookup_hit), 64'd0);
        lookup_op(P1, 21'd3, h, d);
        check_val("p1_inv_miss", 64'(h), 64'd0);

        // fill beats inv: the inv is dropped
        fill_en = 1'b1; fill_addr = Q1; fill_asid = 21'd4; fill_data = 44'h444;
        inv_en = 1'b1; inv_addr = A1;
        @(posedge clk); @(negedge clk);
        fill_en = 1'b0; inv_en = 1'b0;
        lookup_op(A1, 21'd5, h, d);
        check_val("inv_dropped", 64'(d), 64'h55);
        lookup_op(Q1, 21'd4, h, d);
        check_val("q1_data", 64'(d), 64'h444);

        // flush with lookup held; fill and second flush_all issued mid-sweep are dropped
        lookup_en = 1'b1; lookup_addr = A1; lookup_asid = 21'd5;
        flush_all = 1'b1;
        @(posedge clk); @(negedge clk);
        flush_all = 1'b0;
        n = 0; hits = 0;
        while (busy && n < 200) begin
            n++;
            if (n == 10) begin
                fill_en = 1'b1; fill_addr = Z1; fill_asid = 21'd1; fill_data = 44'h99;
            end
            if (n == 11) fill_en = 1'b0;
            flush_all = (n == 20);
            @(posedge clk); @(negedge clk);
            if (lookup_hit) hits++;
        end
        flush_all = 1'b0;
        check_val("flush_len", 64'(n), 64'd64);
        check_val("flush_hits", 64'(hits), 64'd0);
        @(posedge clk); @(negedge clk);
        check_val("post_flush_a1", 64'(lookup_hit), 64'd0);
        lookup_en = 1'b0;
        lookup_op(Z1, 21'd1, h, d);
        check_val("busy_fill_drop", 64'(h), 64'd0);
        lookup_op(Q1, 21'd4, h, d);
        check_val("post_flush_q1", 64'(h), 64'd0);

        // reset in the middle of a sweep restarts from set 0
        flush_all = 1'b1;
        @(posedge clk); @(negedge clk);
        flush_all = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        count_busy(n);
        check_val("midrst_len", 64'(n), 64'd64);
        fill_op(A1, 21'd5, 1'b0, 44'h66);
        lookup_op(A1, 21'd5, h, d);
        check_val("final_data", 64'(d), 64'h66);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
